// File: rtl/constraint_check_sequencer_pkg.sv
// Shared types and constants for the constraint-check sequencer.
// The FSM state enum, the default checker width with its all-pass mask, and a width helper.
package constraint_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CHECK = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_e;

    localparam int NUM_CONS_DEF = 35;
    localparam logic [NUM_CONS_DEF-1:0] ALL_PASS_MASK = '1;

    // Counter width able to hold 0..lat (always at least one bit).
    function automatic int lat_w(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/constraint_check_sequencer_if.sv
// Candidate, checker and output handshake bundle between the sequencer and its environment.
// master = the sequencer side, slave = generator/checker/downstream side.
interface constraint_check_sequencer_if #(
    parameter int SAMPLE_W = 384,
    parameter int NUM_CONS = 35
);
    logic                gen_valid;
    logic                gen_ready;
    logic [SAMPLE_W-1:0] gen_sample;
    logic [SAMPLE_W-1:0] chk_sample;
    logic [NUM_CONS-1:0] chk_result;
    logic                out_valid;
    logic                out_ready;
    logic [SAMPLE_W-1:0] out_sample;

    modport master (
        input  gen_valid, gen_sample, chk_result, out_ready,
        output gen_ready, chk_sample, out_valid, out_sample
    );

    modport slave (
        output gen_valid, gen_sample, chk_result, out_ready,
        input  gen_ready, chk_sample, out_valid, out_sample
    );
endinterface

// File: rtl/constraint_check_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/constraint_check_sequencer.sv
// Pulls candidates from the generator, holds each on the checker inputs for CHECK_LAT cycles,
// forwards passing ones downstream and tracks rejects until the target count or a reject streak ends the run.
module constraint_check_sequencer
    import constraint_seq_pkg::*;
#(
    parameter int SAMPLE_W  = 384,
    parameter int NUM_CONS  = NUM_CONS_DEF,
    parameter int CHECK_LAT = 1,
    parameter int CNT_W     = 32,
    parameter int MAX_TRIES = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [CNT_W-1:0]     i_target_cnt,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_stall_err,
    output logic [CNT_W-1:0]     o_attempt_cnt,
    output logic [CNT_W-1:0]     o_accept_cnt,
    output logic [NUM_CONS-1:0]  o_fail_or,
    constraint_check_sequencer_if.master sq
);
    localparam int                  LAT_W  = lat_w(CHECK_LAT);
    localparam logic [NUM_CONS-1:0] L_PASS = '1;

    state_e               r_state, w_next;
    logic [CNT_W-1:0]     r_target;
    logic [LAT_W-1:0]     r_lat_cnt;
    logic [SAMPLE_W-1:0]  r_sample;
    logic [NUM_CONS-1:0]  r_fail_or;

    logic                 w_clr, w_load, w_att_inc, w_acc_inc;
    logic                 w_stk_inc, w_stk_clr, w_fail_upd;
    logic                 w_lat_done, w_pass, w_streak_hit;
    logic [CNT_W-1:0]     w_attempt, w_accept, w_streak, w_acc_next;

    assign w_lat_done   = (r_lat_cnt == LAT_W'(CHECK_LAT - 1));
    assign w_pass       = (sq.chk_result == L_PASS);
    // The streak counter has not yet counted the reject being judged this cycle.
    assign w_streak_hit = (w_streak == CNT_W'(MAX_TRIES - 1));
    assign w_acc_next   = (w_accept == '1) ? w_accept : (w_accept + CNT_W'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_clr      = 1'b0;
        w_load     = 1'b0;
        w_att_inc  = 1'b0;
        w_acc_inc  = 1'b0;
        w_stk_inc  = 1'b0;
        w_stk_clr  = 1'b0;
        w_fail_upd = 1'b0;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (i_start) begin
                    w_clr  = 1'b1;
                    w_next = (i_target_cnt == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (sq.gen_valid) begin
                    w_load = 1'b1;
                    w_next = CHECK;
                end
            end
            CHECK: begin
                if (w_lat_done) begin
                    w_att_inc = 1'b1;
                    if (w_pass) begin
                        w_stk_clr = 1'b1;
                        w_next    = EMIT;
                    end else begin
                        w_fail_upd = 1'b1;
                        w_stk_inc  = 1'b1;
                        w_next     = w_streak_hit ? ERR : FETCH;
                    end
                end
            end
            EMIT: begin
                if (sq.out_ready) begin
                    w_acc_inc = 1'b1;
                    w_next    = (w_acc_next == r_target) ? DONE : FETCH;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_target  <= '0;
            r_lat_cnt <= '0;
            r_sample  <= '0;
            r_fail_or <= '0;
        end else begin
            if (w_clr) begin
                r_target  <= i_target_cnt;
                r_fail_or <= '0;
            end
            if (w_fail_upd) r_fail_or <= r_fail_or | ~sq.chk_result;
            // Sample register only moves on a fetch, so checker inputs hold through CHECK and EMIT.
            if (w_load) begin
                r_sample  <= sq.gen_sample;
                r_lat_cnt <= '0;
            end else if (r_state == CHECK) begin
                r_lat_cnt <= r_lat_cnt + LAT_W'(1);
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_attempt (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(w_clr),
        .i_inc(w_att_inc), .o_cnt(w_attempt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_accept (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(w_clr),
        .i_inc(w_acc_inc), .o_cnt(w_accept)
    );

    sat_counter #(.CNT_W(CNT_W)) u_streak (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(w_clr | w_stk_clr),
        .i_inc(w_stk_inc), .o_cnt(w_streak)
    );

    assign o_busy        = (r_state == FETCH) || (r_state == CHECK) || (r_state == EMIT);
    assign o_done        = (r_state == DONE) || (r_state == ERR);
    assign o_stall_err   = (r_state == ERR);
    assign o_attempt_cnt = w_attempt;
    assign o_accept_cnt  = w_accept;
    assign o_fail_or     = r_fail_or;

    assign sq.gen_ready  = (r_state == FETCH);
    assign sq.out_valid  = (r_state == EMIT);
    assign sq.chk_sample = r_sample;
    assign sq.out_sample = r_sample;
endmodule

// File: tb/tb_constraint_check_sequencer.sv
// Directed plus randomized runs of the sequencer against a run-level reference model.
module tb_constraint_check_sequencer;
    import constraint_seq_pkg::*;

    localparam int SW = 64;
    localparam int NC = NUM_CONS_DEF;
    localparam int CW = 32;
    localparam int MT = 4;
    localparam int CL = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] target = '0;
    logic          busy, done, serr;
    logic [CW-1:0] att, acc;
    logic [NC-1:0] fo;

    constraint_check_sequencer_if #(.SAMPLE_W(SW), .NUM_CONS(NC)) sq ();

    constraint_check_sequencer #(
        .SAMPLE_W(SW), .NUM_CONS(NC), .CHECK_LAT(CL), .CNT_W(CW), .MAX_TRIES(MT)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_target_cnt(target),
        .o_busy(busy), .o_done(done), .o_stall_err(serr),
        .o_attempt_cnt(att), .o_accept_cnt(acc), .o_fail_or(fo),
        .sq(sq.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [SW-1:0] cand [64];
    logic [SW-1:0] got  [256];
    int            got_cyc [256];
    int            taken = 0, base = 0, out_n = 0, out_base = 0, cyc = 0;
    int            gv_mode = 0, ordy_mode = 0;

    // Checker stand-in: bit0 set passes everything, else two indexed constraints fail.
    function automatic logic [NC-1:0] chk_fn(input logic [SW-1:0] s);
        logic [NC-1:0] r;
        r = ALL_PASS_MASK;
        if (!s[0]) begin
            r[int'(s[13:8]) % NC]  = 1'b0;
            r[int'(s[21:16]) % NC] = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [SW-1:0] mk_pass();
        logic [SW-1:0] v;
        v = {$urandom, $urandom};
        v[0] = 1'b1;
        return v;
    endfunction

    function automatic logic [SW-1:0] mk_fail(input int a, input int b);
        logic [SW-1:0] v;
        v = {$urandom, $urandom};
        v[0] = 1'b0;
        v[13:8] = 6'(a);
        v[21:16] = 6'(b);
        return v;
    endfunction

    assign sq.gen_sample = cand[(taken - base) % 64];
    assign sq.chk_result = chk_fn(sq.chk_sample);

    always @(negedge clk) begin
        sq.gen_valid <= (gv_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        sq.out_ready <= (ordy_mode == 0) ? 1'b1 :
                        (ordy_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sq.gen_valid && sq.gen_ready) taken <= taken + 1;
        if (sq.out_valid && sq.out_ready) begin
            got[out_n % 256]     <= sq.out_sample;
            got_cyc[out_n % 256] <= cyc;
            out_n                <= out_n + 1;
        end
    end

    // Reference: walk the candidate list applying the accept/reject/streak rules.
    int            e_att, e_acc;
    logic [NC-1:0] e_fo;
    logic          e_err;
    logic [SW-1:0] e_s [64];

    task automatic model(input int tgt);
        int streak, i;
        logic [NC-1:0] r;
        e_att = 0; e_acc = 0; e_fo = '0; e_err = 1'b0; streak = 0; i = 0;
        while (tgt != 0) begin
            r = chk_fn(cand[i]);
            e_att++;
            if (r == ALL_PASS_MASK) begin
                e_s[e_acc] = cand[i];
                e_acc++;
                streak = 0;
                if (e_acc == tgt) break;
            end else begin
                e_fo |= ~r;
                streak++;
                if (streak == MT) begin
                    e_err = 1'b1;
                    break;
                end
            end
            i++;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [CW-1:0] t);
        @(negedge clk);
        start = 1'b1;
        target = t;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 1000; k++) begin
            if (done) break;
            @(negedge clk);
        end
        chk("done_reached", 64'(done), 64'd1);
    endtask

    task automatic run(input string tag, input int tgt);
        @(negedge clk);
        base = taken;
        out_base = out_n;
        model(tgt);
        pulse_start(CW'(tgt));
        wait_done();
        chk({tag, "_att"}, 64'(att), 64'(e_att));
        chk({tag, "_acc"}, 64'(acc), 64'(e_acc));
        chk({tag, "_fo"}, 64'(fo), 64'(e_fo));
        chk({tag, "_err"}, 64'(serr), 64'(e_err));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_nout"}, 64'(out_n - out_base), 64'(e_acc));
        for (int k = 0; k < e_acc; k++)
            chk({tag, "_smp"}, got[(out_base + k) % 256], e_s[k]);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_serr"}, 64'(serr), 64'd0);
        chk({tag, "_grdy"}, 64'(sq.gen_ready), 64'd0);
        chk({tag, "_ovld"}, 64'(sq.out_valid), 64'd0);
        chk({tag, "_att"}, 64'(att), 64'd0);
        chk({tag, "_acc"}, 64'(acc), 64'd0);
        chk({tag, "_fo"}, 64'(fo), 64'd0);
        chk({tag, "_csmp"}, sq.chk_sample, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) cand[i] = mk_pass();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("reset");

        // 1: all pass, free-flowing handshakes, one output every three cycles
        run("t1", 3);
        chk("t1_gap1", 64'(got_cyc[(out_base + 1) % 256] - got_cyc[out_base % 256]), 64'd3);
        chk("t1_gap2", 64'(got_cyc[(out_base + 2) % 256] - got_cyc[(out_base + 1) % 256]), 64'd3);

        // 2: two rejects then a pass
        cand[0] = mk_fail(4, 20);
        cand[1] = mk_fail(20, 4);
        cand[2] = mk_pass();
        run("t2", 1);
        chk("t2_att3", 64'(att), 64'd3);
        chk("t2_fo_bits", 64'(fo), (64'd1 << 4) | (64'd1 << 20));
        chk("t2_osmp", sq.out_sample, cand[2]);

        // 3: never passes -> stall error after MT attempts
        for (int i = 0; i < 64; i++) cand[i] = mk_fail($urandom_range(0, 34), $urandom_range(0, 34));
        run("t3", 1);
        chk("t3_att4", 64'(att), 64'(MT));
        chk("t3_serr", 64'(serr), 64'd1);

        // 4: downstream back-pressure in EMIT
        for (int i = 0; i < 64; i++) cand[i] = mk_pass();
        ordy_mode = 2;
        @(negedge clk);
        base = taken;
        pulse_start(CW'(1));
        for (int k = 0; k < 20 && !sq.out_valid; k++) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            chk("t4_ovld", 64'(sq.out_valid), 64'd1);
            chk("t4_osmp", sq.out_sample, cand[0]);
            chk("t4_csmp", sq.chk_sample, cand[0]);
            chk("t4_grdy", 64'(sq.gen_ready), 64'd0);
            chk("t4_acc", 64'(acc), 64'd0);
            @(negedge clk);
        end
        ordy_mode = 0;
        wait_done();
        chk("t4_acc_end", 64'(acc), 64'd1);

        // 5: zero target, then start while busy
        pulse_start('0);
        chk("t5_done", 64'(done), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_att0", 64'(att), 64'd0);
        ordy_mode = 2;
        @(negedge clk);
        base = taken;
        pulse_start(CW'(2));
        for (int k = 0; k < 20 && !sq.out_valid; k++) @(negedge clk);
        pulse_start(CW'(7));
        chk("t5_ign_att", 64'(att), 64'd1);
        chk("t5_ign_acc", 64'(acc), 64'd0);
        chk("t5_ign_busy", 64'(busy), 64'd1);
        ordy_mode = 0;
        wait_done();
        chk("t5_acc2", 64'(acc), 64'd2);
        chk("t5_att2", 64'(att), 64'd2);

        // 6: async reset while in CHECK, then a clean run
        @(negedge clk);
        base = taken;
        pulse_start(CW'(3));
        for (int k = 0; k < 20; k++) begin
            if (busy && !sq.gen_ready && !sq.out_valid) break;
            @(negedge clk);
        end
        chk("t6_in_check", 64'(busy && !sq.gen_ready && !sq.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) cand[i] = ($urandom_range(0, 9) < 6) ? mk_pass() :
            mk_fail($urandom_range(0, 34), $urandom_range(0, 34));
        run("t6_after", 2);

        // Randomized runs with gaps on both handshakes
        gv_mode = 1;
        ordy_mode = 1;
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 64; i++) cand[i] = ($urandom_range(0, 9) < 6) ? mk_pass() :
                mk_fail($urandom_range(0, 34), $urandom_range(0, 34));
            run("rnd", $urandom_range(1, 5));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
